// File: rtl/id_issue_buf_pkg.sv
// Shared definitions for the IF->ID issue buffer.
//   DEF_DEPTH          default queue depth (power of two, >= 2)
//   PC_W/INSN_W/EXP_W  pc word-address, instruction and exception-code widths
//   ISA_NOP            instruction encoding used for cleared entries
//   EXP_NO_EXP         "no exception" code
//   entry_t            one buffered fetch packet
package id_issue_buf_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int PC_W      = 30;
    localparam int INSN_W    = 32;
    localparam int EXP_W     = 3;

    localparam logic [INSN_W-1:0] ISA_NOP    = '0;
    localparam logic [EXP_W-1:0]  EXP_NO_EXP = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
        logic [EXP_W-1:0]  exp_code;
    } entry_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/id_issue_buf_if.sv
// Bundle of fetch-side, decode-side and pipeline-control signals of the
// issue buffer.
//   master: pipeline side (drives if_*, stall, ld_hazard, flush; observes
//           if_ready, id_*, occupancy)
//   slave : the buffer itself
interface id_issue_buf_if
    import id_issue_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
);
    logic                    if_en;
    logic [PC_W-1:0]         if_pc;
    logic [INSN_W-1:0]       if_insn;
    logic [EXP_W-1:0]        if_exp_code;
    logic                    if_ready;

    logic                    id_en;
    logic [PC_W-1:0]         id_pc;
    logic [INSN_W-1:0]       id_insn;
    logic [EXP_W-1:0]        id_exp_code;

    logic                    stall;
    logic                    ld_hazard;
    logic                    flush;
    logic [ptr_w(DEPTH)-1:0] occupancy;

    modport master (
        output if_en, if_pc, if_insn, if_exp_code, stall, ld_hazard, flush,
        input  if_ready, id_en, id_pc, id_insn, id_exp_code, occupancy
    );

    modport slave (
        input  if_en, if_pc, if_insn, if_exp_code, stall, ld_hazard, flush,
        output if_ready, id_en, id_pc, id_insn, id_exp_code, occupancy
    );

endinterface

// File: rtl/id_issue_buf.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular queue
// of {pc, insn, exp_code}. Honours stall, load-hazard bubbles and flush, and
// reports its occupancy to the pipeline controller.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    id_issue_buf_if.slave (fetch handshake, decode outputs, control)
module id_issue_buf
    import id_issue_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    id_issue_buf_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] occ;
    logic          full, empty;
    logic          push, pop, id_en;
    entry_t        head;

    // Wrap bit makes the plain difference the entry count, including DEPTH.
    assign occ   = wr_ptr_q - rd_ptr_q;
    assign full  = (occ == PW'(DEPTH));
    assign empty = (occ == '0);

    // if_ready looks only at fullness, never at this cycle's pop, so the
    // fetch side has no combinational path from stall/ld_hazard.
    assign push  = bus.if_en && !full && !bus.flush;
    assign id_en = !empty && !bus.ld_hazard;
    assign pop   = id_en && !bus.stall;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            // Redirect: drop everything, including this cycle's push and pop.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entries are cleared on reset so the head reads as a NOP with no
    // exception while the queue is empty after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: '0, insn: ISA_NOP, exp_code: EXP_NO_EXP};
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{pc:       bus.if_pc,
                                         insn:     bus.if_insn,
                                         exp_code: bus.if_exp_code};
        end
    end

    // No bypass: the head always comes from the array.
    assign head            = mem_q[rd_ptr_q[AW-1:0]];

    assign bus.if_ready    = !full;
    assign bus.id_en       = id_en;
    assign bus.id_pc       = head.pc;
    assign bus.id_insn     = head.insn;
    assign bus.id_exp_code = head.exp_code;
    assign bus.occupancy   = occ;

endmodule

// File: tb/tb_id_issue_buf.sv
module tb_id_issue_buf;
    import id_issue_buf_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    id_issue_buf_if #(.DEPTH(DEPTH)) bus ();

    id_issue_buf #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    entry_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [INSN_W-1:0] mk_insn(input logic [PC_W-1:0] pc);
        return 32'hA500_0000 | INSN_W'(pc);
    endfunction

    function automatic logic [EXP_W-1:0] mk_exp(input logic [PC_W-1:0] pc);
        return pc[EXP_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch packet; if accepted is expected, record it in the scoreboard.
    task automatic drive_push(input logic [PC_W-1:0] pc, input bit expect_it);
        bus.if_en       = 1'b1;
        bus.if_pc       = pc;
        bus.if_insn     = mk_insn(pc);
        bus.if_exp_code = mk_exp(pc);
        if (expect_it) exp_q.push_back('{pc: pc, insn: mk_insn(pc), exp_code: mk_exp(pc)});
    endtask

    // Monitor: every real pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset && bus.id_en && !bus.stall && !bus.flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc 0x%0h expected no entry at %0t", bus.id_pc, $time);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("pop_pc",   64'(bus.id_pc),       64'(e.pc));
                chk("pop_insn", 64'(bus.id_insn),     64'(e.insn));
                chk("pop_exp",  64'(bus.id_exp_code), 64'(e.exp_code));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_en       = 1'b0;
        bus.if_pc       = '0;
        bus.if_insn     = '0;
        bus.if_exp_code = '0;
        bus.stall       = 1'b0;
        bus.ld_hazard   = 1'b0;
        bus.flush       = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_occ",   64'(bus.occupancy), 64'd0);
            chk("idle_id_en", 64'(bus.id_en),     64'd0);
            chk("idle_ready", 64'(bus.if_ready),  64'd1);
            chk("idle_insn",  64'(bus.id_insn),   64'd0);
        end
        chk("idle_pc",  64'(bus.id_pc),       64'd0);
        chk("idle_exp", 64'(bus.id_exp_code), 64'd0);

        // Fill under stall, reject when full, then drain
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(PC_W'(32'h10 + i), 1'b1);
            tick();
        end
        bus.if_en = 1'b0;
        @(negedge clk);
        chk("full_occ",   64'(bus.occupancy), 64'd4);
        chk("full_ready", 64'(bus.if_ready),  64'd0);
        tick();
        drive_push(PC_W'(32'h99), 1'b0);
        tick();
        bus.if_en = 1'b0;
        @(negedge clk);
        chk("full_hold_occ", 64'(bus.occupancy), 64'd4);
        tick();
        bus.stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_en", 64'(bus.id_en), 64'd1);
            chk("drain_pc", 64'(bus.id_pc), 64'(32'h10 + k));
            tick();
        end
        @(negedge clk);
        chk("drained_en",  64'(bus.id_en),     64'd0);
        chk("drained_occ", 64'(bus.occupancy), 64'd0);

        // Streaming across several pointer wraps
        tick();
        for (int i = 0; i < 20; i++) begin
            drive_push(PC_W'(32'h100 + i), 1'b1);
            @(negedge clk);
            if (i > 0) begin
                chk("stream_occ", 64'(bus.occupancy), 64'd1);
                chk("stream_pc",  64'(bus.id_pc),     64'(32'h100 + i - 1));
            end
            tick();
        end
        bus.if_en = 1'b0;
        @(negedge clk);
        chk("stream_last_pc", 64'(bus.id_pc),     64'h113);
        chk("stream_last_occ", 64'(bus.occupancy), 64'd1);
        tick();
        @(negedge clk);
        chk("stream_end_occ", 64'(bus.occupancy), 64'd0);

        // Flush racing a push and a pop
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(PC_W'(32'h30 + i), 1'b1);
            tick();
        end
        drive_push(PC_W'(32'h3F), 1'b0);
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("pre_flush_occ", 64'(bus.occupancy), 64'd3);
        tick();
        bus.flush = 1'b0;
        bus.if_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_occ",   64'(bus.occupancy), 64'd0);
        chk("flush_id_en", 64'(bus.id_en),     64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("post_flush_id_en", 64'(bus.id_en), 64'd0);
        end

        // Flush wins over stall
        tick();
        bus.stall = 1'b1;
        drive_push(PC_W'(32'h50), 1'b1);
        tick();
        bus.if_en = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("stall_flush_pre_occ", 64'(bus.occupancy), 64'd1);
        tick();
        bus.flush = 1'b0;
        exp_q.delete();
        bus.stall = 1'b0;
        @(negedge clk);
        chk("stall_flush_occ",   64'(bus.occupancy), 64'd0);
        chk("stall_flush_id_en", 64'(bus.id_en),     64'd0);

        // Load-use hazard bubble
        tick();
        bus.ld_hazard = 1'b1;
        drive_push(PC_W'(32'h20), 1'b1);
        tick();
        bus.if_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hazard_id_en", 64'(bus.id_en),     64'd0);
            chk("hazard_pc",    64'(bus.id_pc),     64'h20);
            chk("hazard_occ",   64'(bus.occupancy), 64'd1);
            tick();
        end
        bus.ld_hazard = 1'b0;
        @(negedge clk);
        chk("hazard_release_en", 64'(bus.id_en), 64'd1);
        chk("hazard_release_pc", 64'(bus.id_pc), 64'h20);
        tick();
        @(negedge clk);
        chk("hazard_end_occ", 64'(bus.occupancy), 64'd0);

        // Asynchronous reset mid-stream
        tick();
        bus.stall = 1'b1;
        drive_push(PC_W'(32'h40), 1'b1);
        tick();
        drive_push(PC_W'(32'h41), 1'b1);
        tick();
        bus.if_en = 1'b0;
        @(negedge clk);
        chk("prereset_occ", 64'(bus.occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_occ",   64'(bus.occupancy),   64'd0);
        chk("areset_id_en", 64'(bus.id_en),       64'd0);
        chk("areset_ready", 64'(bus.if_ready),    64'd1);
        chk("areset_pc",    64'(bus.id_pc),       64'd0);
        chk("areset_insn",  64'(bus.id_insn),     64'd0);
        chk("areset_exp",   64'(bus.id_exp_code), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_reset_id_en", 64'(bus.id_en),     64'd0);
            chk("after_reset_occ",   64'(bus.occupancy), 64'd0);
        end

        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
